// File: rtl/sw_debounce.sv
// Sixteen-channel slide-switch debouncer: two-flop synchronizer, shared sample-tick
// prescaler, and a per-bit stability counter that gates updates to the clean state.
module sw_debounce #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  output logic [15:0] sw_clean,
  output logic [15:0] sw_rise,
  output logic [15:0] sw_fall,
  output logic        sw_changed,
  output logic        tick
);

  localparam int              PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]      CMAX = 4'(STABLE_TICKS - 1);

  logic [15:0]   sync_p0;
  logic [15:0]   sync;
  logic [PW-1:0] pcnt;
  logic [3:0]    cnt     [16];
  logic [3:0]    cnt_nxt [16];
  logic [15:0]   differs;
  logic [15:0]   upd;
  logic [15:0]   clean_nxt;
  logic [15:0]   rise_nxt;
  logic [15:0]   fall_nxt;

  // stage: two-flop synchronizer; only sync feeds the debounce logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync    <= '0;
    end else begin
      sync_p0 <= sw;
      sync    <= sync_p0;
    end
  end

  // stage: free-running sample prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == PMAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick    = (pcnt == PMAX);
  assign differs = sync ^ sw_clean;

  // Any agreement between sync and clean restarts qualification, tick or not.
  always_comb begin
    upd       = '0;
    clean_nxt = sw_clean;
    for (int i = 0; i < 16; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!differs[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CMAX) begin
          cnt_nxt[i]   = '0;
          upd[i]       = 1'b1;
          clean_nxt[i] = sync[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  assign rise_nxt = upd & sync;
  assign fall_nxt = upd & ~sync;

  // stage: counters, clean state and edge pulses, all registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
      sw_clean   <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      sw_clean   <= clean_nxt;
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
      sw_changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce at TICK_DIV=4, STABLE_TICKS=3: step vectors scored via an
// expected-result queue, plus hand sequences for bounce, short pulses and reset.
module tb_sw_debounce;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = '0;
  logic [15:0] sw_clean;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;
  logic        sw_changed;
  logic        tick;

  sw_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .sw_clean(sw_clean),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_changed(sw_changed),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] clean;
  } vec_t;

  typedef struct {
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] clean;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the next pulse, then scores it against the queued expectation.
  task automatic wait_pulse(input string name, input int lo, input int hi);
    exp_t e;
    int   lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (sw_changed || (sw_rise != 16'h0) || (sw_fall != 16'h0)) begin
        lat = k;
        break;
      end
    end
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue: no expected entry queued", name);
      return;
    end
    e = sbq.pop_front();
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no pulse within 20 cycles, required latency %0d..%0d", name, lo, hi);
      return;
    end
    chk({name, "_latency_ok"}, 64'(lat >= lo && lat <= hi), 64'(1));
    chk({name, "_rise"},    64'(sw_rise),    64'(e.rise));
    chk({name, "_fall"},    64'(sw_fall),    64'(e.fall));
    chk({name, "_clean"},   64'(sw_clean),   64'(e.clean));
    chk({name, "_changed"}, 64'(sw_changed), 64'(1));
    step(1);
    chk({name, "_one_cycle"}, 64'({sw_rise, sw_fall, sw_changed}), 64'(0));
    chk({name, "_clean_hold"}, 64'(sw_clean), 64'(e.clean));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   bad;
    int   pulses;

    vt[0] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001};
    vt[1] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};
    vt[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};
    vt[3] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    vt[4] = '{16'hA5A5, 16'hA5A5, 16'h0000, 16'hA5A5};
    vt[5] = '{16'h5A5A, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    vt[6] = '{16'h0000, 16'h0000, 16'h5A5A, 16'h0000};

    reset = 1'b1;
    sw    = '0;
    step(3);
    chk("reset_state", 64'({sw_clean, sw_rise, sw_fall, sw_changed, tick}), 64'(0));

    // Idle after release: prescaler counts from 0, so tick lands when k%4 == 3.
    reset  = 1'b0;
    bad    = 0;
    pulses = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      if (tick !== ((k % TD) == (TD - 1))) bad++;
      if (((sw_rise | sw_fall | sw_clean) != 16'h0) || sw_changed) pulses++;
    end
    chk("tick_period", 64'(bad), 64'(0));
    chk("idle_quiet", 64'(pulses), 64'(0));

    for (int i = 0; i < 7; i++) begin
      sw = vt[i].sw;
      sbq.push_back('{vt[i].rise, vt[i].fall, vt[i].clean});
      wait_pulse($sformatf("vec%0d", i), (ST - 1) * TD + 3, ST * TD + 2);
      step(5);
    end

    // sw[3] bounces with a 3-cycle half period, never stable long enough.
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if ((c % 3) == 0) sw[3] = ~sw[3];
      step(1);
      if (((sw_rise | sw_fall) != 16'h0) || sw_changed) pulses++;
    end
    sw = '0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (((sw_rise | sw_fall) != 16'h0) || sw_changed) pulses++;
    end
    chk("bounce_no_pulse", 64'(pulses), 64'(0));
    chk("bounce_clean", 64'(sw_clean), 64'(0));

    // A 7-cycle pulse is shorter than (ST-1)*TD and must be filtered.
    pulses = 0;
    sw = 16'h0002;
    for (int c = 0; c < 7; c++) begin
      step(1);
      if (((sw_rise | sw_fall) != 16'h0) || sw_changed) pulses++;
    end
    sw = '0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (((sw_rise | sw_fall) != 16'h0) || sw_changed) pulses++;
    end
    chk("short_pulse_filtered", 64'(pulses), 64'(0));
    chk("short_pulse_clean", 64'(sw_clean), 64'(0));

    // Switches held through reset debounce from a zeroed prescaler: exactly 12 cycles.
    reset = 1'b1;
    sw    = 16'h00F0;
    step(2);
    reset = 1'b0;
    sbq.push_back('{16'h00F0, 16'h0000, 16'h00F0});
    wait_pulse("held_thru_reset", 12, 12);
    step(3);

    // Reset mid-qualification on bit 0 clears everything asynchronously.
    sw = 16'h00F1;
    step(8);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({sw_clean, sw_rise, sw_fall, sw_changed, tick}), 64'(0));
    sw = '0;
    step(3);
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (((sw_rise | sw_fall) != 16'h0) || sw_changed) pulses++;
    end
    chk("post_reset_no_pulse", 64'(pulses), 64'(0));
    chk("post_reset_clean", 64'(sw_clean), 64'(0));
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per debounce sample tick (1 ms at 100 MHz); legal range 2..2^24.
REQ-002 Parameter STABLE_TICKS, default 4, consecutive ticks an input must differ from its clean value before the clean value changes; legal range 1..15.
REQ-003 clk  input  1  system clock, 100 MHz, all state on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sw  input  16  raw slide-switch inputs, asynchronous to clk.
REQ-006 sw_clean  output  16  registered, debounced switch state, suitable for driving led directly.
REQ-007 sw_rise  output  16  one-cycle pulse per bit when sw_clean[i] goes 0->1.
REQ-008 sw_fall  output  16  one-cycle pulse per bit when sw_clean[i] goes 1->0.
REQ-009 sw_changed  output  1  registered OR of all sw_rise and sw_fall bits, same cycle as the pulses.
REQ-010 tick  output  1  one-cycle sample-tick pulse, exposed for verification.

Function
REQ-011 Each sw bit SHALL pass through a two-flop synchronizer; only the second flop (sync[i]) feeds the rest of the logic.
REQ-012 Prescaler: counter 0..TICK_DIV-1, increments every cycle and wraps to 0; tick SHALL be 1 exactly in the cycle the counter equals TICK_DIV-1.
REQ-013 Per bit i: 4-bit counter cnt[i], compared against sync[i] != sw_clean[i] ("differs").
REQ-014 If not differs: cnt[i] SHALL clear to 0 on the next edge, regardless of tick (any bounce restarts qualification).
REQ-015 If differs and tick=0: cnt[i] SHALL hold.
REQ-016 If differs, tick=1, and cnt[i] < STABLE_TICKS-1: cnt[i] SHALL increment.
REQ-017 If differs, tick=1, and cnt[i] = STABLE_TICKS-1: on that edge sw_clean[i] <= sync[i], cnt[i] <= 0, and sw_rise[i] or sw_fall[i] SHALL assert for exactly that one following cycle.
REQ-018 sw_rise, sw_fall, and sw_changed SHALL be 0 in every cycle without a qualifying update; multiple bits MAY pulse in the same cycle.
REQ-019 Bits SHALL be fully independent; a change on one bit SHALL NOT affect another bit's counter.
REQ-020 Latency from a clean, bounce-free sw step to the sw_clean change: 2 sync cycles plus STABLE_TICKS ticks, i.e. between (STABLE_TICKS-1)*TICK_DIV+3 and STABLE_TICKS*TICK_DIV+2 cycles.
REQ-021 A pulse on sw shorter than (STABLE_TICKS-1)*TICK_DIV cycles SHALL never reach sw_clean.

Reset
REQ-022 While reset=1: synchronizer flops, prescaler, all cnt[i], sw_clean, sw_rise, sw_fall, sw_changed, and tick SHALL be 0, asynchronously.
REQ-023 After reset deasserts, prescaler SHALL start from 0; switches held high through reset SHALL debounce normally and produce sw_rise pulses.
REQ-024 Reset asserted mid-qualification SHALL discard partial counts with no pulse.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-025 reset released, sw=16'h0000 for 50 cycles -> sw_clean=0, no rise/fall pulses, tick every 4th cycle.
REQ-026 sw 0->16'h0001 held -> sw_clean[0]=1 within 11..14 cycles, sw_rise=16'h0001 and sw_changed=1 for one cycle, sw_fall=0.
REQ-027 sw[3] toggles every 3 cycles for 40 cycles, then holds at 0 -> sw_clean[3] stays 0, no pulses.
REQ-028 sw 16'h0000->16'hFFFF in one cycle -> all bits update in the same cycle, sw_rise=16'hFFFF for one cycle; back to 0 -> sw_fall=16'hFFFF for one cycle.
REQ-029 sw=16'h00F0 held through reset, reset released -> sw_rise=16'h00F0 after the debounce latency; reset reasserted mid-qualification on another bit -> all outputs 0, no pulse.
